// File: rtl/deconv2d_multich.sv
// Multi-channel transposed 2-D convolution engine.
// C input planes of NxN pixels are scattered through per-channel kw x kw kernels
// into one saturating accumulator plane of side O=(N-1)*S+kw, which is then
// streamed out row-major over a valid/ready interface.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | all outputs low; enable latches S/kw and starts a run
// CLEAR    | zero one accumulator word per cycle over the full depth
// LOAD_K   | accept C*kw*kw weights, channel-major then row then column
// WAIT_PIX | accept one pixel strobe
// MAC      | one kernel tap per cycle for the latched pixel
// DRAIN    | stream O*O accumulator words with valid/ready
// DONE     | done (and cfg_err) held until enable drops
module deconv2d_multich #(
  parameter int N          = 2,
  parameter int K          = 3,
  parameter int C          = 2,
  parameter int PIXEL_BITS = 8,
  parameter int ACC_BITS   = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [$clog2(K):0]                   stride,
  input  logic [$clog2(K):0]                   kernel_width,
  input  logic                                 strobe_signal_kernel,
  input  logic [PIXEL_BITS-1:0]                kernel_weight,
  input  logic                                 strobe_signal_pixel,
  input  logic [PIXEL_BITS-1:0]                pixel,
  input  logic [$clog2(N*N)-1:0]               pixel_number,
  input  logic [((C > 1) ? $clog2(C) : 1)-1:0] pixel_channel,
  output logic                                 ready,
  output logic                                 out_valid,
  output logic [ACC_BITS-1:0]                  out_data,
  output logic                                 out_last,
  input  logic                                 out_ready,
  output logic                                 done,
  output logic                                 cfg_err
);

  localparam int SW     = $clog2(K) + 1;
  localparam int PNW    = $clog2(N*N);
  localparam int CHW    = (C > 1) ? $clog2(C) : 1;
  localparam int DEPTH  = N*K*N*K;
  localparam int AW     = $clog2(DEPTH + 1);
  localparam int WDEPTH = C*K*K;
  localparam int WAW    = $clog2(WDEPTH + 1);
  localparam int PCW    = $clog2(C*N*N + 1);
  localparam int PW     = 2*PIXEL_BITS;
  // one guard bit above the wider of accumulator and product detects overflow
  localparam int SUMW   = ((ACC_BITS > PW) ? ACC_BITS : PW) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD_K, S_WAIT_PIX, S_MAC, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0]         s_q, kw_q, ti_q, tj_q;
  logic [AW-1:0]         o_side_q, clr_cnt_q, oidx_q, r_q, c_q;
  logic [WAW-1:0]        widx_q;
  logic [PCW-1:0]        pcnt_q;
  logic [PIXEL_BITS-1:0] pix_q;
  logic [CHW-1:0]        ch_q;
  logic                  cfg_err_q;

  logic [ACC_BITS-1:0]   acc_mem [DEPTH];
  logic [PIXEL_BITS-1:0] w_mem   [WDEPTH];

  logic                  cfg_bad, pix_ok, row_end, tap_last;
  logic [AW-1:0]         o_side_d, oo, mac_addr;
  logic [WAW-1:0]        kwsq, nk, w_addr;
  logic [PW-1:0]         prod;
  logic [SUMW-1:0]       sum;
  logic [ACC_BITS-1:0]   acc_sat;

  // Config check, geometry, tap addressing and the saturating multiply-accumulate.
  always_comb begin
    cfg_bad  = (stride == '0) || (stride > SW'(K)) ||
               (kernel_width == '0) || (kernel_width > SW'(K));
    o_side_d = AW'(N-1) * AW'(stride) + AW'(kernel_width);
    oo       = o_side_q * o_side_q;
    kwsq     = WAW'(kw_q) * WAW'(kw_q);
    nk       = WAW'(C) * kwsq;
    pix_ok   = strobe_signal_pixel &&
               ({1'b0, pixel_number} < (PNW+1)'(N*N)) &&
               ({1'b0, pixel_channel} < (CHW+1)'(C));
    row_end  = (tj_q == kw_q - 1'b1);
    tap_last = row_end && (ti_q == kw_q - 1'b1);
    mac_addr = (r_q * AW'(s_q) + AW'(ti_q)) * o_side_q + c_q * AW'(s_q) + AW'(tj_q);
    w_addr   = WAW'(ch_q) * kwsq + WAW'(ti_q) * WAW'(kw_q) + WAW'(tj_q);
    prod     = PW'(pix_q) * PW'(w_mem[w_addr]);
    sum      = SUMW'(acc_mem[mac_addr]) + SUMW'(prod);
    acc_sat  = (sum > SUMW'({ACC_BITS{1'b1}})) ? {ACC_BITS{1'b1}} : ACC_BITS'(sum);
  end

  // Next-state logic; dropping enable mid-run aborts straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (enable) state_d = cfg_bad ? S_DONE : S_CLEAR;
      S_CLEAR:    if (clr_cnt_q == '0) state_d = S_LOAD_K;
      S_LOAD_K:   if (strobe_signal_kernel && (widx_q == nk - 1'b1)) state_d = S_WAIT_PIX;
      S_WAIT_PIX: if (pix_ok) state_d = S_MAC;
      S_MAC:      if (tap_last) state_d = (pcnt_q == PCW'(C*N*N)) ? S_DRAIN : S_WAIT_PIX;
      S_DRAIN:    if (out_ready && (oidx_q == oo - 1'b1)) state_d = S_DONE;
      S_DONE:     if (!enable) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (!enable && (state_q != S_IDLE) && (state_q != S_DONE)) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Run configuration, counters and the latched pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0; kw_q <= '0; o_side_q <= '0; clr_cnt_q <= '0; oidx_q <= '0;
      r_q <= '0; c_q <= '0; widx_q <= '0; pcnt_q <= '0; pix_q <= '0;
      ch_q <= '0; ti_q <= '0; tj_q <= '0; cfg_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (enable) begin
          s_q       <= stride;
          kw_q      <= kernel_width;
          o_side_q  <= o_side_d;
          cfg_err_q <= cfg_bad;
          clr_cnt_q <= AW'(DEPTH - 1);
          widx_q    <= '0;
          pcnt_q    <= '0;
          oidx_q    <= '0;
        end
        S_CLEAR:  clr_cnt_q <= clr_cnt_q - 1'b1;
        S_LOAD_K: if (strobe_signal_kernel) widx_q <= widx_q + 1'b1;
        S_WAIT_PIX: if (pix_ok) begin
          pix_q  <= pixel;
          r_q    <= AW'(pixel_number) / AW'(N);
          c_q    <= AW'(pixel_number) % AW'(N);
          ch_q   <= pixel_channel;
          ti_q   <= '0;
          tj_q   <= '0;
          pcnt_q <= pcnt_q + 1'b1;
        end
        S_MAC: begin
          if (row_end) begin
            tj_q <= '0;
            ti_q <= ti_q + 1'b1;
          end else begin
            tj_q <= tj_q + 1'b1;
          end
        end
        S_DRAIN: if (out_ready) oidx_q <= oidx_q + 1'b1;
        S_DONE:  if (!enable) cfg_err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Accumulator and weight storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR)    acc_mem[clr_cnt_q] <= '0;
    else if (state_q == S_MAC) acc_mem[mac_addr]  <= acc_sat;
    if ((state_q == S_LOAD_K) && strobe_signal_kernel) w_mem[widx_q] <= kernel_weight;
  end

  // Outputs decode from the state register so reset and IDLE force them low.
  always_comb begin
    ready     = (state_q == S_LOAD_K) || (state_q == S_WAIT_PIX);
    out_valid = (state_q == S_DRAIN);
    out_data  = out_valid ? acc_mem[oidx_q] : '0;
    out_last  = out_valid && (oidx_q == oo - 1'b1);
    done      = (state_q == S_DONE);
    cfg_err   = cfg_err_q;
  end

endmodule

// File: tb/tb_deconv2d_multich.sv
// Bench for deconv2d_multich: two instances (32- and 16-bit accumulators) share
// all inputs; a scoreboard queue holds expected samples and a negedge monitor
// pops and compares them whenever a sample is consumed.
module tb_deconv2d_multich;
  localparam int N = 2, K = 3, C = 2, PB = 8;
  localparam int DEPTH = N*K*N*K;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [$clog2(K):0] stride = '0, kernel_width = '0;
  logic sk = 1'b0, sp = 1'b0, out_ready = 1'b1;
  logic [PB-1:0] kweight = '0, pixel = '0;
  logic [$clog2(N*N)-1:0] pnum = '0;
  logic [0:0] pch = '0;
  logic ready_a, ov_a, ol_a, done_a, ce_a;
  logic ready_b, ov_b, ol_b, done_b, ce_b;
  logic [31:0] od_a;
  logic [15:0] od_b;

  typedef struct { longint d32; longint d16; bit last; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int rdy_mode = 0, nsamp = 0, stall_cnt = 0;
  bit held_v = 0;
  longint held_d = 0;

  int w [C][K][K];
  longint acc [DEPTH];
  int cur_s, cur_kw, cur_o;
  int pix_v[$], pix_i[$], pix_c[$];
  longint exp1 [9]  = '{11, 33, 22, 44, 110, 66, 33, 77, 44};
  longint exp2 [16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};

  deconv2d_multich #(.N(N), .K(K), .C(C), .PIXEL_BITS(PB), .ACC_BITS(32)) u_dut32 (
    .clk(clk), .rst(rst), .enable(enable), .stride(stride), .kernel_width(kernel_width),
    .strobe_signal_kernel(sk), .kernel_weight(kweight), .strobe_signal_pixel(sp),
    .pixel(pixel), .pixel_number(pnum), .pixel_channel(pch), .ready(ready_a),
    .out_valid(ov_a), .out_data(od_a), .out_last(ol_a), .out_ready(out_ready),
    .done(done_a), .cfg_err(ce_a));

  deconv2d_multich #(.N(N), .K(K), .C(C), .PIXEL_BITS(PB), .ACC_BITS(16)) u_dut16 (
    .clk(clk), .rst(rst), .enable(enable), .stride(stride), .kernel_width(kernel_width),
    .strobe_signal_kernel(sk), .kernel_weight(kweight), .strobe_signal_pixel(sp),
    .pixel(pixel), .pixel_number(pnum), .pixel_channel(pch), .ready(ready_b),
    .out_valid(ov_b), .out_data(od_b), .out_last(ol_b), .out_ready(out_ready),
    .done(done_b), .cfg_err(ce_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: stability under backpressure and scoreboard compare on each consumed sample.
  always @(negedge clk) begin
    if (rst) held_v = 0;
    else begin
      if (held_v) begin
        chk("valid_held", ov_a, 1);
        chk("data_stable", od_a, held_d);
      end
      if (ov_a && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sample: got %0d, expected no sample", od_a);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data32", od_a, e.d32);
          chk("data16", od_b, e.d16);
          chk("last", ol_a, e.last);
          chk("valid16", ov_b, 1);
        end
        held_v = 0;
        nsamp++;
      end else if (ov_a) begin
        held_v = 1;
        held_d = od_a;
      end else held_v = 0;
    end
  end

  // Downstream ready: always, random, or a 5-cycle stall on sample 3.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: if (ov_a && nsamp == 3 && stall_cnt < 5) begin
           out_ready = 1'b0;
           stall_cnt++;
         end else out_ready = 1'b1;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic push_exp(input longint v, input bit last);
    exp_t e;
    e.d32 = (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    e.d16 = (v > 65535) ? 65535 : v;
    e.last = last;
    q.push_back(e);
  endtask

  task automatic setup(input int s, input int kw);
    cur_s = s; cur_kw = kw; cur_o = (N-1)*s + kw;
    foreach (acc[k]) acc[k] = 0;
    nsamp = 0; stall_cnt = 0;
    q.delete(); pix_v.delete(); pix_i.delete(); pix_c.delete();
  endtask

  // Reference: each accepted pixel adds pixel*w into an kw x kw window at (r*S, c*S).
  task automatic model_run();
    for (int k = 0; k < pix_v.size(); k++) begin
      int r, c;
      r = pix_i[k] / N; c = pix_i[k] % N;
      for (int i = 0; i < cur_kw; i++)
        for (int j = 0; j < cur_kw; j++)
          acc[(r*cur_s + i)*cur_o + c*cur_s + j] += longint'(pix_v[k]) * w[pix_c[k]][i][j];
    end
    for (int k = 0; k < cur_o*cur_o; k++) push_exp(acc[k], k == cur_o*cur_o - 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_a && n < 300) begin tick(); n++; end
    if (!ready_a) chk("ready_timeout", ready_a, 1);
  endtask

  task automatic start(input int s, input int kw);
    stride = 3'(s); kernel_width = 3'(kw); enable = 1'b1;
    tick();
  endtask

  task automatic load_kernel();
    wait_ready();
    for (int ch = 0; ch < C; ch++)
      for (int i = 0; i < cur_kw; i++)
        for (int j = 0; j < cur_kw; j++) begin
          sk = 1'b1; kweight = 8'(w[ch][i][j]);
          tick();
        end
    sk = 1'b0;
  endtask

  task automatic send_pixel(input int p, input int idx, input int ch, input bit spur, output int busy);
    wait_ready();
    sp = 1'b1; pixel = 8'(p); pnum = 2'(idx); pch = 1'(ch);
    tick();
    sp = 1'b0;
    busy = 0;
    while (!ready_a && !ov_a && !done_a && busy < 100) begin
      busy++;
      if (spur && busy == 1) begin sp = 1'b1; pixel = 8'd99; pnum = '0; pch = '0; end
      tick();
      sp = 1'b0;
    end
  endtask

  task automatic finish_run();
    int n = 0;
    while (!done_a && n < 1000) begin tick(); n++; end
    chk("done", done_a, 1);
    chk("done16", done_b, 1);
    chk("cfg_err_clean", ce_a, 0);
    chk("queue_drained", q.size(), 0);
    q.delete();
    enable = 1'b0;
    tick();
    chk("done_cleared", done_a, 0);
  endtask

  task automatic full_run(input bit spur, input bit wrong_kind);
    int busy;
    start(cur_s, cur_kw);
    if (wrong_kind) begin
      wait_ready();
      sp = 1'b1; pixel = 8'd77; pnum = '0; pch = '0;
      tick();
      sp = 1'b0;
    end
    load_kernel();
    if (wrong_kind) begin
      sk = 1'b1; kweight = 8'd200;
      tick();
      sk = 1'b0;
    end
    for (int k = 0; k < pix_v.size(); k++) begin
      send_pixel(pix_v[k], pix_i[k], pix_c[k], spur && k == 2, busy);
      chk("busy_cycles", busy, cur_kw*cur_kw);
    end
    finish_run();
  endtask

  task automatic scenario1();
    setup(1, 2);
    foreach (w[a, b, c]) w[a][b][c] = 1;
    for (int k = 0; k < 4; k++) begin pix_v.push_back(10*(k+1)); pix_i.push_back(k); pix_c.push_back(0); end
    for (int k = 0; k < 4; k++) begin pix_v.push_back(k+1); pix_i.push_back(k); pix_c.push_back(1); end
    foreach (exp1[k]) push_exp(exp1[k], k == 8);
    rdy_mode = 0;
    full_run(1, 1);
  endtask

  initial begin
    int busy;
    repeat (3) tick();
    chk("rst_ready", ready_a, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", ready_a, 0);
    chk("idle_ready16", ready_b, 0);
    chk("idle_valid", ov_a, 0);
    chk("idle_data", od_a, 0);
    chk("idle_last", ol_a, 0);
    chk("idle_done", done_a, 0);
    chk("idle_cfg_err", ce_a, 0);

    scenario1();

    // stride 2 leaves a separated 2x2 block per pixel; stall at sample 3
    setup(2, 2);
    foreach (w[a, b, c]) w[a][b][c] = 1;
    for (int k = 0; k < 4; k++) begin pix_v.push_back(10*(k+1)); pix_i.push_back(k); pix_c.push_back(0); end
    for (int k = 0; k < 4; k++) begin pix_v.push_back(0); pix_i.push_back(k); pix_c.push_back(1); end
    foreach (exp2[k]) push_exp(exp2[k], k == 15);
    rdy_mode = 2;
    full_run(0, 0);
    chk("stall_cycles", stall_cnt, 5);

    // saturation: two channels of 255*255 per output word
    setup(1, 1);
    foreach (w[a, b, c]) w[a][b][c] = 255;
    for (int ch = 0; ch < C; ch++)
      for (int k = 0; k < N*N; k++) begin pix_v.push_back(255); pix_i.push_back(k); pix_c.push_back(ch); end
    for (int k = 0; k < 4; k++) push_exp(130050, k == 3);
    rdy_mode = 0;
    full_run(0, 0);

    // illegal configurations
    setup(1, 0);
    start(1, 0);
    finish_run_err: begin
      int n = 0;
      while (!done_a && n < 50) begin tick(); n++; end
      chk("err_done", done_a, 1);
      chk("err_cfg_err", ce_a, 1);
      chk("err_cfg_err16", ce_b, 1);
      enable = 1'b0;
      tick();
      chk("err_done_clear", done_a, 0);
      chk("err_cfg_clear", ce_a, 0);
    end
    start(4, 2);
    tick();
    chk("stride_err", ce_a, 1);
    enable = 1'b0;
    tick();

    // enable drop while waiting for pixels aborts to IDLE
    setup(1, 2);
    foreach (w[a, b, c]) w[a][b][c] = 1;
    start(1, 2);
    load_kernel();
    chk("abort_pre_ready", ready_a, 1);
    enable = 1'b0;
    tick();
    chk("abort_ready", ready_a, 0);
    chk("abort_done", done_a, 0);

    // asynchronous reset in the middle of MAC
    start(1, 2);
    load_kernel();
    wait_ready();
    sp = 1'b1; pixel = 8'd50; pnum = '0; pch = '0;
    tick();
    sp = 1'b0;
    tick();
    enable = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready_mac", ready_a, 0);
    chk("rst_valid", ov_a, 0);
    chk("rst_data", od_a, 0);
    chk("rst_last", ol_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cfg_err", ce_a, 0);
    tick();
    rst = 1'b0;
    tick();
    scenario1();

    // randomized runs with repeated indices and random backpressure
    for (int run = 0; run < 5; run++) begin
      setup($urandom_range(1, K), $urandom_range(1, K));
      foreach (w[a, b, c]) w[a][b][c] = $urandom_range(0, 255);
      for (int k = 0; k < C*N*N; k++) begin
        pix_v.push_back($urandom_range(0, 255));
        pix_i.push_back($urandom_range(0, N*N-1));
        pix_c.push_back($urandom_range(0, C-1));
      end
      model_run();
      rdy_mode = 1;
      full_run(run == 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/deconv2d_multich.md
Name: deconv2d_multich

Overview:
Multi-channel transposed 2D convolution engine. It is the parametrised successor of the single-channel deconv2D block. C input channels, each N×N, are scattered through per-channel kw×kw kernels and summed into one output plane in an internal accumulator RAM. The block adds saturating accumulation, runtime config checking, and a valid/ready output stream in place of random-access readout.

Parameters:
N, 2, input plane side (pixels per row/column)
K, 3, maximum kernel width and maximum stride
C, 2, number of input channels
PIXEL_BITS, 8, unsigned pixel and weight width
ACC_BITS, 32, unsigned accumulator and output width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  start when high in IDLE; abort when low elsewhere
stride  in  $clog2(K)+1  stride S, valid range 1..K, sampled at start
kernel_width  in  $clog2(K)+1  kernel width kw, valid range 1..K, sampled at start
strobe_signal_kernel  in  1  kernel weight write strobe
kernel_weight  in  PIXEL_BITS  weight value
strobe_signal_pixel  in  1  pixel write strobe
pixel  in  PIXEL_BITS  pixel value
pixel_number  in  $clog2(N*N)  row-major pixel index
pixel_channel  in  $clog2(C) (min 1)  channel of the pixel
ready  out  1  block accepts a strobe this cycle
out_valid  out  1  out_data is valid
out_data  out  ACC_BITS  output sample
out_last  out  1  marks the final output sample
out_ready  in  1  downstream accepts the sample
done  out  1  run complete
cfg_err  out  1  illegal S or kw seen at start

Behaviour:
- Reset (async) and the IDLE state: all outputs are 0. The state machine enters IDLE. RAM contents are don't-care.
- Output side: O=(N-1)*S+kw. Accumulator RAM depth is N*K*N*K.
- IDLE: when enable=1, latch S and kw.
  - If S or kw is 0 or greater than K: set cfg_err=1, go to DONE.
  - Otherwise go to CLEAR.
- CLEAR: write 0 to one address per cycle over the full RAM depth. ready=0.
- LOAD_K: ready=1.
  - Each cycle with strobe_signal_kernel=1 stores the weight at the next index (channel-major, then row, then column).
  - After C*kw*kw weights, go to WAIT_PIX.
- WAIT_PIX: ready=1.
  - A pixel strobe sampled at edge t latches pixel, pixel_number (r=idx/N, c=idx%N) and channel.
  - ready=0 from edge t.
  - The pixel is accepted and counted only if pixel_number<N*N and channel<C. Otherwise it is ignored and ready stays 1.
- MAC: one tap per cycle, over edges t+1..t+kw*kw, with taps (i,j) in row-major order.
  - Address: (r*S+i)*O+(c*S+j).
  - Update: acc = min(acc + pixel*w[ch][i][j], 2^ACC_BITS-1), saturating.
  - ready=1 again after edge t+kw*kw, returning to WAIT_PIX.
  - After C*N*N accepted pixels, go to DRAIN instead.
- Strobes while ready=0 are ignored. A strobe of the wrong kind for the current state is ignored.
- A repeated pixel_number/channel accumulates again. There is no duplicate tracking.
- Overlapping taps (S<kw) sum. Positions no tap reaches (S>kw) read 0.
- DRAIN: stream O*O samples in row-major order.
  - out_valid stays high and out_data stays stable until out_ready=1.
  - The sample is consumed on a cycle where out_valid and out_ready are both 1. The next sample is presented on the following cycle, giving one sample per cycle under continuous out_ready.
  - out_last=1 with sample O*O-1.
- DONE: done=1 (and cfg_err if set), held until enable=0, then go to IDLE with both cleared.
- enable=0 in any state other than IDLE/DONE: abort to IDLE on the next edge. All outputs go to 0 and partial results are discarded.

Test Plan:
- N=2,K=3,C=2, S=1, kw=2, all 8 weights=1.
  - Stimulus: ch0 pixels 10,20,30,40; ch1 pixels 1,2,3,4.
  - Required: stream 11,33,22,44,110,66,33,77,44; out_last on the 9th sample; then done=1.
- S=2, kw=2, all weights=1, ch0 pixels 10,20,30,40, ch1 all 0.
  - Required: 16 samples 10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40.
- Handshake timing, kw=2: after each accepted pixel strobe, ready=0 for exactly 4 cycles.
  - A pixel strobe asserted while ready=0 is ignored (no RAM change; final stream unchanged).
- ACC_BITS=16, all weights=255, S=1, kw=1.
  - Stimulus: both channels pixel 255 at every index.
  - Required: every sample = 65535 (saturated, not 130050 mod 65536).
- Backpressure: hold out_ready=0 for 5 cycles at sample 3.
  - Required: out_valid=1 and out_data stable throughout; no sample lost or duplicated.
- Error and abort cases:
  - kernel_width=0 at start → cfg_err=1, done=1, out_valid never asserted.
  - rst pulse during MAC → all outputs 0 immediately.
  - After rst, a fresh run produces the first scenario's stream exactly.
